// File: rtl/lab1_sweeper.sv
// Truth-table sweeper: walks {A,B,C,D} through all 16 vectors, lets each one
// settle for SETTLE_CYCLES cycles, then captures Q_IN into TRUTH and tallies ONES.
module lab1_sweeper #(
  parameter int SETTLE_CYCLES = 1
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic        START,
  input  logic        Q_IN,
  output logic        A,
  output logic        B,
  output logic        C,
  output logic        D,
  output logic [15:0] TRUTH,
  output logic [4:0]  ONES,
  output logic        BUSY,
  output logic        DONE
);

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_DRIVE  = 2'd1;
  localparam logic [1:0] S_SAMPLE = 2'd2;
  localparam logic [1:0] S_DONE   = 2'd3;

  localparam logic [7:0] SETTLE_LAST = 8'(SETTLE_CYCLES - 1);

  logic [1:0]  state_q, state_d;
  logic [3:0]  idx_q,   idx_d;
  logic [7:0]  cnt_q,   cnt_d;
  logic [15:0] truth_q, truth_d;
  logic [4:0]  ones_q,  ones_d;
  logic [3:0]  abcd_q,  abcd_d;

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    cnt_d   = cnt_q;
    truth_d = truth_q;
    ones_d  = ones_q;
    case (state_q)
      S_IDLE, S_DONE: begin
        if (START) begin
          state_d = S_DRIVE;
          idx_d   = 4'd0;
          cnt_d   = 8'd0;
          truth_d = 16'h0000;
          ones_d  = 5'd0;
        end
      end
      S_DRIVE: begin
        cnt_d = cnt_q + 8'd1;
        if (cnt_q == SETTLE_LAST) state_d = S_SAMPLE;
      end
      S_SAMPLE: begin
        truth_d[idx_q] = Q_IN;
        ones_d         = ones_q + {4'd0, Q_IN};
        cnt_d          = 8'd0;
        // Last vector ends the sweep instead of wrapping the index.
        if (idx_q == 4'hF) begin
          state_d = S_DONE;
        end else begin
          idx_d   = idx_q + 4'd1;
          state_d = S_DRIVE;
        end
      end
      default: state_d = S_IDLE;
    endcase
    abcd_d = (state_d == S_DRIVE || state_d == S_SAMPLE) ? idx_d : 4'd0;
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q <= S_IDLE;
      idx_q   <= 4'd0;
      cnt_q   <= 8'd0;
      truth_q <= 16'h0000;
      ones_q  <= 5'd0;
      abcd_q  <= 4'd0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      cnt_q   <= cnt_d;
      truth_q <= truth_d;
      ones_q  <= ones_d;
      abcd_q  <= abcd_d;
    end
  end

  assign {A, B, C, D} = abcd_q;
  assign TRUTH        = truth_q;
  assign ONES         = ones_q;
  assign BUSY         = (state_q == S_DRIVE) || (state_q == S_SAMPLE);
  assign DONE         = (state_q == S_DONE);

endmodule

// File: tb/tb_lab1_sweeper.sv
// Scoreboard bench for lab1_sweeper: stimulus pushes expected sweeps (start edge,
// done edge, truth table); a negedge monitor checks every cycle against them.
module tb_lab1_sweeper;

  localparam int S   = 3;
  localparam int VEC = S + 1;
  localparam int SW  = 16 * VEC;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic        q_in;
  logic        a, b, c, d;
  logic [15:0] truth;
  logic [4:0]  ones;
  logic        busy, done;
  logic [15:0] func = 16'h0000;

  typedef struct {
    logic [15:0] tt;
    int          n1;
    int          st;
    int          dn;
  } exp_t;

  exp_t        sb[$];
  int          cyc = 0;
  logic        rst_edge = 1'b0;
  logic        has_last = 1'b0;
  logic [15:0] last_tt = 16'h0000;
  int          tests = 0;
  int          errors = 0;

  lab1_sweeper #(.SETTLE_CYCLES(S)) dut (
    .CLK(clk), .RST(rst), .START(start), .Q_IN(q_in),
    .A(a), .B(b), .C(c), .D(d),
    .TRUTH(truth), .ONES(ones), .BUSY(busy), .DONE(done)
  );

  // Function under test: a plain lookup table indexed by the stimulus vector.
  assign q_in = func[{a, b, c, d}];

  always #5 clk = ~clk;

  always @(posedge clk) begin
    cyc      <= cyc + 1;
    rst_edge <= rst;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s @cyc %0d: got %0h expected %0h", name, cyc, act, exp);
    end
  endtask

  // Monitor: decides what the DUT must show after the most recent edge.
  always @(negedge clk) begin
    if (rst_edge) begin
      sb.delete();
      has_last = 1'b0;
      chk("rst_busy",  32'(busy), 0);
      chk("rst_done",  32'(done), 0);
      chk("rst_abcd",  32'({a, b, c, d}), 0);
      chk("rst_truth", 32'(truth), 0);
      chk("rst_ones",  32'(ones), 0);
    end else if (sb.size() > 0 && cyc == sb[0].dn) begin
      chk("done_flag",  32'(done), 1);
      chk("done_busy",  32'(busy), 0);
      chk("done_abcd",  32'({a, b, c, d}), 0);
      chk("done_truth", 32'(truth), 32'(sb[0].tt));
      chk("done_ones",  32'(ones), 32'(sb[0].n1));
      last_tt  = sb[0].tt;
      has_last = 1'b1;
      void'(sb.pop_front());
    end else if (sb.size() > 0 && cyc >= sb[0].st) begin
      int          j, v;
      logic [31:0] mask;
      logic [15:0] pt;
      j    = cyc - sb[0].st;
      v    = j / VEC;
      mask = (32'd1 << v) - 32'd1;
      pt   = sb[0].tt & mask[15:0];
      chk("run_busy",  32'(busy), 1);
      chk("run_done",  32'(done), 0);
      chk("run_abcd",  32'({a, b, c, d}), 32'(v));
      chk("run_truth", 32'(truth), 32'(pt));
      chk("run_ones",  32'(ones), 32'($countones(pt)));
    end else begin
      chk("idle_busy",  32'(busy), 0);
      chk("idle_done",  32'(done), 32'(has_last));
      chk("idle_abcd",  32'({a, b, c, d}), 0);
      chk("idle_truth", 32'(truth), has_last ? 32'(last_tt) : 32'd0);
      chk("idle_ones",  32'(ones), has_last ? 32'($countones(last_tt)) : 32'd0);
    end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic tick_until(input int target);
    while (cyc < target) tick(1);
  endtask

  task automatic start_sweep(input logic [15:0] f, output int st);
    func = f;
    st   = cyc + 1;
    sb.push_back('{f, $countones(f), st, st + SW});
    start = 1'b1;
    tick(1);
    start = 1'b0;
  endtask

  task automatic wait_done(input int budget);
    int n = 0;
    while (sb.size() != 0 && n < budget) begin
      @(posedge clk);
      n++;
    end
    #1;
    if (sb.size() != 0) begin
      tests++;
      errors++;
      $display("FAIL done_timeout @cyc %0d: %0d sweeps pending, expected 0", cyc, sb.size());
      sb.delete();
    end
  endtask

  initial begin
    int st, st2;
    tick(2);
    rst = 1'b0;
    tick(10);

    // Reference function: 0 on vectors 0,1,2,3,4,8,12.
    start_sweep(16'hEEE0, st);
    wait_done(SW + 10);
    tick(3);

    start_sweep(16'hFFFF, st);
    wait_done(SW + 10);
    start_sweep(16'h0000, st);
    wait_done(SW + 10);
    tick(2);

    // START pulsed mid-sweep at vector 7 must be ignored.
    start_sweep(16'hEEE0, st);
    tick_until(st + 7 * VEC + 1);
    start = 1'b1;
    tick(1);
    start = 1'b0;
    wait_done(SW + 10);

    // Reset at vector 9, with START high to show reset wins.
    start_sweep(16'($urandom), st);
    tick_until(st + 9 * VEC + 1);
    rst   = 1'b1;
    start = 1'b1;
    tick(1);
    rst   = 1'b0;
    start = 1'b0;
    tick(3);
    rst   = 1'b1;
    start = 1'b1;
    tick(1);
    rst   = 1'b0;
    start = 1'b0;
    tick(2);
    start_sweep(16'($urandom), st);
    wait_done(SW + 10);

    // START held across DONE: back-to-back sweeps with a one-cycle DONE.
    func  = 16'($urandom);
    st    = cyc + 1;
    st2   = st + SW + 1;
    sb.push_back('{func, $countones(func), st, st + SW});
    sb.push_back('{func, $countones(func), st2, st2 + SW});
    start = 1'b1;
    tick_until(st2);
    start = 1'b0;
    wait_done(2 * SW + 10);

    for (int i = 0; i < 6; i++) begin
      tick($urandom_range(0, 5));
      start_sweep(16'($urandom), st);
      if ($urandom_range(0, 1) == 1) begin
        tick($urandom_range(1, SW - 4));
        start = 1'b1;
        tick(1);
        start = 1'b0;
      end
      wait_done(SW + 10);
    end
    tick(3);

    $display("[TB] %0d tests run, %0d failed", tests, errors);
    $finish;
  end

endmodule
